rot_shift_pipe: RTL and testbench
=================================

Name: rot_shift_pipe

Overview:
- Parametrised, pipelined rotate/shift unit; successor to the fixed 32-bit rotate-right-by-2 block.
- Takes a WIDTH-bit operand, a run-time shift amount and an operation code; produces the result after a fixed pipeline latency.
- Valid/ready handshakes on both sides; a downstream stall propagates back to the source.
- Sits in the datapath wherever the fixed-constant rotators were used, e.g. hash round logic and ALU shift ops.

Parameters:
- WIDTH, 32, operand width in bits. Must be a power of two, at least 4; elaboration error otherwise.
- SHW, $clog2(WIDTH), width of the amount field. Derived; not to be overridden.
- TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  unit can accept an input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHW  shift/rotate amount, 0..WIDTH-1.
- in_op  input  2  operation: 00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right).
- in_tag  input  TAGW  tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_tag  output  TAGW  tag of this result.
- out_zero  output  1  high when out_data == 0.

Behaviour:
- Pipeline structure:
  - SHW register stages; stage k applies a conditional move of 2^k positions, selected by amt bit k.
  - Each stage holds its own valid bit and carries the op, amt, tag and partial data.
  - Latency is exactly SHW cycles from input acceptance to out_valid (5 cycles for WIDTH=32).
- Throughput and handshake:
  - Sustained throughput is one operation per cycle.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv. An input transfers on in_valid && in_ready.
  - When adv=0, every stage holds its contents.
  - When adv=1, every stage shifts forward; bubbles (valid=0) propagate as normal entries.
  - The output transfers on out_valid && out_ready. out_data, out_tag and out_zero stay stable while out_valid && !out_ready.
- Operation semantics, with a = in_amt and x = in_data:
  - ROR: res[i] = x[(i+a) mod WIDTH].
  - ROL: res[i] = x[(i-a) mod WIDTH].
  - SRL: res[i] = x[i+a] if i+a < WIDTH, else 0.
  - SRA: res[i] = x[i+a] if i+a < WIDTH, else x[WIDTH-1].
- Edge cases:
  - a = 0 returns x unchanged for all ops.
  - a covers the full range 0..WIDTH-1; no out-of-range amount exists.
- Reset and timing:
  - On rst_n low, all stage valids and out_valid clear to 0 immediately.
  - Datapath registers reset to 0, so out_data=0, out_tag=0, out_zero=1.
  - Operations in flight when reset is asserted are discarded; none is emitted after reset release.
  - in_ready is 1 during reset, because out_valid=0. Inputs presented while rst_n is low are not accepted.
  - No combinational path from in_* to out_*. in_ready depends combinationally only on out_valid and out_ready.
- Ordering: results emerge in acceptance order. Tags are never reordered, dropped or duplicated.

Test Plan (WIDTH=32):
- ROR, amt=2, x=0x00000003, tag=5 -> out_data=0xC0000000, out_tag=5, out_zero=0, out_valid exactly 5 cycles after acceptance.
- ROL amt=4 on x=0x80000001 -> 0x00000018. SRL amt=31 on 0x80000000 -> 0x00000001. SRA amt=4 on 0x80000000 -> 0xF8000000. SRA amt=4 on 0x70000000 -> 0x07000000.
- amt=0 for all four ops on 0xDEADBEEF -> 0xDEADBEEF each time. SRL amt=1 on 0x00000001 -> 0x00000000 with out_zero=1.
- Streaming and backpressure:
  - Issue 10 back-to-back ops with tags 0..9.
  - Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall.
  - Outputs held stable during the stall; all 10 results arrive in tag order with correct data; no loss or duplication.
- Reset mid-operation: accept 3 ops, assert rst_n low for 1 cycle while 3 are in flight -> out_valid=0 immediately; no results for those tags ever appear. A new op after release returns normally with 5-cycle latency.
- Randomised sweep, 1000 ops with random op/amt/data and random out_ready -> every result matches the reference model; ordering preserved.

Source files
------------

// File: rtl/rot_shift_pipe_if.sv
// Handshake bundle for rot_shift_pipe.
// Source side: in_*; sink side: out_*.
interface rot_shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;
  logic             out_zero;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_op,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_tag,
    output out_zero
  );

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_op,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_zero
  );
endinterface

// File: rtl/rot_shift_pipe.sv
// Pipelined rotate/shift unit, one log2 step per stage.
// Stage k holds pre-step data; its 2^k move feeds k+1.
module rot_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input logic           clk,
  input logic           rst_n,
  rot_shift_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  generate
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("rot_shift_pipe: WIDTH must be a power of two >= 4");
    end
  endgenerate

  logic             adv;
  logic             v_q   [SHW];
  logic [1:0]       op_q  [SHW];
  logic [SHW-1:0]   amt_q [SHW];
  logic [TAGW-1:0]  tag_q [SHW];
  logic [WIDTH-1:0] d_q   [SHW];
  logic [WIDTH-1:0] mv    [SHW];

  // One conditional move of sh positions.
  // SRA fills with the current MSB, which stays
  // the original sign bit across all steps.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             en,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      unique case (op)
        OP_ROR: r = (d >> sh) | (d << (WIDTH - sh));
        OP_ROL: r = (d << sh) | (d >> (WIDTH - sh));
        OP_SRL: r = d >> sh;
        OP_SRA: r = $signed(d) >>> sh;
      endcase
    end
    return r;
  endfunction

  assign adv = !v_q[SHW-1] || bus.out_ready;

  // Apply each stage's move to its held operand
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      mv[k] = step(d_q[k], op_q[k], amt_q[k][k], 1 << k);
    end
  end

  // Shift every stage forward together, or hold all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        v_q[k]   <= 1'b0;
        op_q[k]  <= '0;
        amt_q[k] <= '0;
        tag_q[k] <= '0;
        d_q[k]   <= '0;
      end
    end else if (adv) begin
      v_q[0]   <= bus.in_valid;
      op_q[0]  <= bus.in_op;
      amt_q[0] <= bus.in_amt;
      tag_q[0] <= bus.in_tag;
      d_q[0]   <= bus.in_data;
      for (int k = 1; k < SHW; k++) begin
        v_q[k]   <= v_q[k-1];
        op_q[k]  <= op_q[k-1];
        amt_q[k] <= amt_q[k-1];
        tag_q[k] <= tag_q[k-1];
        d_q[k]   <= mv[k-1];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data  = mv[SHW-1];
  assign bus.out_tag   = tag_q[SHW-1];
  assign bus.out_zero  = ~|mv[SHW-1];
endmodule

// File: tb/tb_rot_shift_pipe.sv
// Scoreboard bench for rot_shift_pipe, WIDTH=32.
// Driver pushes expectations; monitor pops on output.
module tb_rot_shift_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rot_shift_pipe_if #(.WIDTH(W), .TAGW(TW)) bus();

  rot_shift_pipe #(.WIDTH(W), .TAGW(TW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [4:0]    a;
    logic [W-1:0]  x;
    logic [TW-1:0] t;
    logic [W-1:0]  e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(
    input logic [W-1:0] x, input logic [1:0] op, input int a);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'b00: r[i] = x[(i + a) % W];
        2'b01: r[i] = x[(i - a + W) % W];
        2'b10: r[i] = (i + a < W) ? x[i + a] : 1'b0;
        default: r[i] = (i + a < W) ? x[i + a] : x[W-1];
      endcase
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [4:0] a,
                      input logic [W-1:0] x, input logic [TW-1:0] t,
                      input logic [W-1:0] e, input bit lat);
    exp_t s;
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_amt = a;
    bus.in_data = x;
    bus.in_tag = t;
    #4;
    while (!bus.in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got=%0d want=1", bus.in_ready);
        return;
      end
      @(negedge clk);
      #4;
    end
    s.data = e;
    s.tag = t;
    s.cyc = cyc;
    s.lat = lat;
    sb.push_back(s);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 0);
  endtask

  // Random backpressure during the sweep
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on transfer, check holds during stalls
  initial begin
    exp_t e;
    logic stall_p;
    logic [W-1:0] pd;
    logic [TW-1:0] pt;
    stall_p = 1'b0;
    pd = '0;
    pt = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stall_p = 1'b0;
        continue;
      end
      if (stall_p) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, pd);
        check("hold_tag", bus.out_tag, pt);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got=%0h/%0h want=none",
                   bus.out_tag, bus.out_data);
        end else begin
          e = sb.pop_front();
          check("data", bus.out_data, e.data);
          check("tag", bus.out_tag, e.tag);
          check("zero", bus.out_zero, e.data == '0);
          if (e.lat) check("latency", 64'(cyc - e.cyc), 5);
        end
      end
      stall_p = bus.out_valid && !bus.out_ready;
      if (stall_p) begin
        check("stall_in_ready", bus.in_ready, 0);
        pd = bus.out_data;
        pt = bus.out_tag;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got=running want=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [4:0] a;
    logic [W-1:0] x;
    vecs = '{
      '{2'b00, 5'd2,  32'h00000003, 4'h5, 32'hC0000000},
      '{2'b01, 5'd4,  32'h80000001, 4'h1, 32'h00000018},
      '{2'b10, 5'd31, 32'h80000000, 4'h2, 32'h00000001},
      '{2'b11, 5'd4,  32'h80000000, 4'h3, 32'hF8000000},
      '{2'b11, 5'd4,  32'h70000000, 4'h4, 32'h07000000},
      '{2'b00, 5'd0,  32'hDEADBEEF, 4'h6, 32'hDEADBEEF},
      '{2'b01, 5'd0,  32'hDEADBEEF, 4'h7, 32'hDEADBEEF},
      '{2'b10, 5'd0,  32'hDEADBEEF, 4'h8, 32'hDEADBEEF},
      '{2'b11, 5'd0,  32'hDEADBEEF, 4'h9, 32'hDEADBEEF},
      '{2'b10, 5'd1,  32'h00000001, 4'hA, 32'h00000000},
      '{2'b00, 5'd31, 32'h00000001, 4'hB, 32'h00000002},
      '{2'b01, 5'd31, 32'h00000001, 4'hC, 32'h80000000}
    };
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_amt = '0;
    bus.in_data = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_zero", bus.out_zero, 1);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].x,
           vecs[i].t, vecs[i].e, 1'b1);
    idle();
    wait_drain(100);

    fork
      begin
        repeat (8) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++)
      send(2'b00, 5'(i), 32'h1, 4'(i),
           (i == 0) ? 32'h1 : (32'h1 << (32 - i)), 1'b0);
    idle();
    wait_drain(100);

    send(2'b01, 5'd1, 32'h1, 4'hD, 32'h2, 1'b0);
    idle();
    idle();
    send(2'b10, 5'd3, 32'h80, 4'hE, 32'h10, 1'b0);
    send(2'b11, 5'd3, 32'h80, 4'h6, 32'h10, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    bus.in_tag = 4'hF;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_tag", bus.out_tag, 0);
    check("mid_rst_zero", bus.out_zero, 1);
    check("mid_rst_ready", bus.in_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    send(2'b00, 5'd2, 32'h3, 4'h7, 32'hC0000000, 1'b1);
    idle();
    wait_drain(100);
    repeat (20) @(negedge clk);

    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 5'($urandom_range(0, 31));
      x = $urandom;
      send(op, a, x, 4'(i), ref_model(x, op, int'(a)), 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    wait_drain(1000);
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
